// File: rtl/onehot_rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onehot_rr_sched_pkg
// Brief    : Shared types, defaults and index helper for the round-robin scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package onehot_rr_sched_pkg;

    localparam int NREQ_DEF  = 15;
    localparam int IDX_W_DEF = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    function automatic int next_idx_mod(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_rr_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : onehot_rr_sched_rr_pick
// Brief    : Combinational round-robin pick: first request at or after last+1.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_rr_sched_rr_pick
    import onehot_rr_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic             o_any,
    output logic [IDX_W-1:0] o_pick
);

    logic [IDX_W-1:0] w_start;
    logic [NREQ-1:0]  w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    assign w_start = IDX_W'(next_idx_mod(int'(i_last), NREQ));

    // Doubling the vector turns the wrap-around search into a plain shift.
    assign w_rot = NREQ'({i_req, i_req} >> w_start);

    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = IDX_W'(i);
            end
        end
    end

    assign o_any  = |i_req;
    assign w_sum  = {1'b0, w_start} + {1'b0, w_off};
    assign o_pick = (w_sum >= (IDX_W+1)'(NREQ)) ? IDX_W'(w_sum - (IDX_W+1)'(NREQ))
                                                : IDX_W'(w_sum);

endmodule
`default_nettype wire

// File: rtl/onehot_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : onehot_rr_sched
// Brief    : Round-robin owner scheduler with hold limit driving a one-hot select.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_rr_sched
    import onehot_rr_sched_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_release,
    output logic             o_grant_valid,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic [NREQ-1:0]  o_grant_onehot,
    output logic             o_timeout
);

    localparam int c_HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LIM = c_HOLD_W'(MAX_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_SAT = (MAX_HOLD == 0) ? {c_HOLD_W{1'b1}}
                                                                 : c_HOLD_W'(MAX_HOLD);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_valid;
    logic [IDX_W-1:0]    r_idx;
    logic [NREQ-1:0]     r_onehot;
    logic                r_timeout;
    logic [IDX_W-1:0]    r_last;
    logic [c_HOLD_W-1:0] r_hold;

    logic                w_any;
    logic [IDX_W-1:0]    w_pick;
    logic [NREQ-1:0]     w_pick_oh;
    logic                w_load;
    logic                w_drop;
    logic                w_limit;
    logic                w_to_nxt;
    logic                w_valid_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [NREQ-1:0]     w_onehot_nxt;
    logic [IDX_W-1:0]    w_last_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;

    onehot_rr_sched_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req  (i_req),
        .i_last (r_last),
        .o_any  (w_any),
        .o_pick (w_pick)
    );

    always_comb begin
        w_pick_oh         = '0;
        w_pick_oh[w_pick] = 1'b1;
    end

    assign w_limit = (MAX_HOLD != 0) && (r_hold == c_HOLD_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Voluntary exits outrank the hold limit so a release never raises timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        w_to_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = OWN;
                    w_load      = 1'b1;
                end
            end
            OWN: begin
                if (i_release || !i_req[r_idx]) begin
                    w_state_nxt = IDLE;
                    w_drop      = 1'b1;
                end else if (w_limit) begin
                    w_state_nxt = IDLE;
                    w_drop      = 1'b1;
                    w_to_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_drop      = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_valid_nxt  = r_valid;
        w_idx_nxt    = r_idx;
        w_onehot_nxt = r_onehot;
        w_last_nxt   = r_last;
        w_hold_nxt   = r_hold;
        if (w_load) begin
            w_valid_nxt  = 1'b1;
            w_idx_nxt    = w_pick;
            w_onehot_nxt = w_pick_oh;
            w_last_nxt   = w_pick;
            w_hold_nxt   = c_HOLD_W'(1);
        end else if (w_drop) begin
            w_valid_nxt  = 1'b0;
            w_idx_nxt    = '0;
            w_onehot_nxt = '0;
            w_hold_nxt   = '0;
        end else if ((r_state == OWN) && (r_hold != c_HOLD_SAT)) begin
            w_hold_nxt   = r_hold + c_HOLD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_idx     <= '0;
            r_onehot  <= '0;
            r_timeout <= 1'b0;
            r_last    <= IDX_W'(NREQ - 1);
            r_hold    <= '0;
        end else begin
            r_valid   <= w_valid_nxt;
            r_idx     <= w_idx_nxt;
            r_onehot  <= w_onehot_nxt;
            r_timeout <= w_to_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
        end
    end

    assign o_grant_valid  = r_valid;
    assign o_grant_idx    = r_idx;
    assign o_grant_onehot = r_onehot;
    assign o_timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_rr_sched
// Brief    : Directed table-driven bench for the round-robin one-hot scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_rr_sched;

    localparam int NREQ     = 15;
    localparam int IDX_W    = 4;
    localparam int MAX_HOLD = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req;
    logic             rel;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [NREQ-1:0]  grant_onehot;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string            name;
        logic [NREQ-1:0]  req;
        logic             rel;
        logic             exp_v;
        logic [IDX_W-1:0] exp_idx;
        logic             exp_to;
    } vec_t;

    vec_t vecs[$];

    onehot_rr_sched #(
        .NREQ     (NREQ),
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (req),
        .i_release      (rel),
        .o_grant_valid  (grant_valid),
        .o_grant_idx    (grant_idx),
        .o_grant_onehot (grant_onehot),
        .o_timeout      (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [NREQ-1:0] oh_of(input logic v, input logic [IDX_W-1:0] idx);
        logic [NREQ-1:0] r;
        r = '0;
        if (v) r[idx] = 1'b1;
        return r;
    endfunction

    function automatic void add(input string n, input logic [NREQ-1:0] r, input logic rl,
                                input logic v, input logic [IDX_W-1:0] idx, input logic to);
        vec_t t;
        t.name = n; t.req = r; t.rel = rl; t.exp_v = v; t.exp_idx = idx; t.exp_to = to;
        vecs.push_back(t);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input logic v, input logic [IDX_W-1:0] idx, input logic to);
        cmp({name, ".valid"},   32'(grant_valid),  32'(v));
        cmp({name, ".idx"},     32'(grant_idx),    v ? 32'(idx) : 32'd0);
        cmp({name, ".onehot"},  32'(grant_onehot), 32'(oh_of(v, idx)));
        cmp({name, ".timeout"}, 32'(timeout),      32'(to));
    endtask

    task automatic step(input logic [NREQ-1:0] r, input logic rl);
        @(negedge clk);
        req = r;
        rel = rl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        rel = 1'b0;

        add("idle_noreq",   15'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
        add("first_grant",  15'h0001, 1'b0, 1'b1, 4'd0, 1'b0);
        add("hold0",        15'h0001, 1'b0, 1'b1, 4'd0, 1'b0);
        add("release0",     15'h0001, 1'b1, 1'b0, 4'd0, 1'b0);
        add("regrant0",     15'h0001, 1'b0, 1'b1, 4'd0, 1'b0);
        add("release0b",    15'h0001, 1'b1, 1'b0, 4'd0, 1'b0);
        add("idle_rel_ign", 15'h0001, 1'b1, 1'b1, 4'd0, 1'b0);
        add("withdraw0",    15'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
        add("idle_again",   15'h0000, 1'b0, 1'b0, 4'd0, 1'b0);
        add("grant3",       15'h0208, 1'b0, 1'b1, 4'd3, 1'b0);
        add("drop3",        15'h0200, 1'b0, 1'b0, 4'd0, 1'b0);
        add("grant9",       15'h0200, 1'b0, 1'b1, 4'd9, 1'b0);
        add("release9",     15'h0200, 1'b1, 1'b0, 4'd0, 1'b0);
        add("wrap_to0",     15'h0001, 1'b0, 1'b1, 4'd0, 1'b0);
        add("others_move",  15'h7FFF, 1'b0, 1'b1, 4'd0, 1'b0);
        add("release0c",    15'h0003, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            add($sformatf("rr_grant%0d", k), 15'h7FFF, 1'b0, 1'b1, IDX_W'(k % NREQ), 1'b0);
            add($sformatf("rr_rel%0d", k),   15'h7FFF, 1'b1, 1'b0, 4'd0, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset", 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].rel);
            chk(vecs[i].name, vecs[i].exp_v, vecs[i].exp_idx, vecs[i].exp_to);
        end

        // Hold limit: owner 4 keeps requesting and never releases.
        @(negedge clk);
        req = '0; rel = 1'b0; rst = 1'b1;
        #1;
        chk("reset2", 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= MAX_HOLD; k++) begin
            step(15'h0010, 1'b0);
            chk($sformatf("hold4_c%0d", k), 1'b1, 4'd4, 1'b0);
        end
        step(15'h0010, 1'b0);
        chk("timeout_pulse", 1'b0, 4'd0, 1'b1);
        step(15'h0010, 1'b0);
        chk("regrant4", 1'b1, 4'd4, 1'b0);
        for (int k = 2; k <= MAX_HOLD; k++) begin
            step(15'h0010, 1'b0);
        end
        chk("hold4_at_limit", 1'b1, 4'd4, 1'b0);
        step(15'h0010, 1'b1);
        chk("rel_at_limit", 1'b0, 4'd0, 1'b0);
        step(15'h0000, 1'b0);
        chk("after_rel_lim", 1'b0, 4'd0, 1'b0);

        // Asynchronous reset while owned, checked before any clock edge.
        step(15'h7FFF, 1'b0);
        chk("grant5", 1'b1, 4'd5, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst", 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_grant", 1'b1, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
